// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C transaction arbiter.
// Contents: sequencer state encoding, field widths and direction constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_WAIT_END
    } state_t;

    localparam int   ADDR_W   = 7;
    localparam int   BYTE_W   = 8;
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/i2c_rr_arb2.sv
// Two-way round-robin arbiter with a last-served pointer.
// Ports:
//   clk, reset  - clock, synchronous active-low reset
//   req[1:0]    - requests
//   update      - record 'served' as the last-served requester
//   served      - index of the requester just served
//   gnt[1:0]    - one-hot combinational winner (0 when no request)
module i2c_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] gnt
);

    // Out of reset, requester 1 counts as last served so requester 0 wins a tie.
    logic last_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_reg <= 1'b1;
        end else if (update) begin
            last_reg <= served;
        end
    end

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_reg ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Two-requester transaction arbiter and byte sequencer in front of an I2C master.
// Ports:
//   clk, reset                    - clock, synchronous active-low reset
//   req/req_rw/req_addr/req_len   - per-requester transaction descriptors
//   req_wdata                     - current write byte per requester
//   gnt, wr_ack, rd_valid, done, err (2 bits each, per requester), rd_data
//   mst_*                         - handshake with the I2C master engine
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            req_rw,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*LEN_W-1:0]    req_len,
    input  logic [2*BYTE_W-1:0]   req_wdata,
    output logic [1:0]            gnt,
    output logic [1:0]            wr_ack,
    output logic [1:0]            rd_valid,
    output logic [BYTE_W-1:0]     rd_data,
    output logic [1:0]            done,
    output logic [1:0]            err,
    output logic                  mst_start,
    input  logic                  mst_ready,
    input  logic                  mst_send,
    output logic [BYTE_W-1:0]     mst_datasend,
    output logic                  mst_sended,
    input  logic                  mst_receive,
    input  logic [BYTE_W-1:0]     mst_datareceive,
    output logic                  mst_received,
    output logic                  mst_last
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [ADDR_W-1:0] addr_arr  [2];
    logic [LEN_W-1:0]  len_arr   [2];
    logic [BYTE_W-1:0] wdata_arr [2];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]   = req_len[gi*LEN_W +: LEN_W];
            assign wdata_arr[gi] = req_wdata[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    state_t            state_reg;
    logic [1:0]        gnt_reg, wr_ack_reg, rd_valid_reg, done_reg, err_reg;
    logic [BYTE_W-1:0] rd_data_reg, datasend_reg;
    logic              start_reg, sended_reg, received_reg, last_reg;
    logic              sel_reg, rw_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg, rem_reg;
    logic [TMR_W-1:0]  tmr_reg;
    logic              send_d_reg, recv_d_reg;

    logic [1:0] arb_gnt;
    logic       win_idx, arb_update, send_rise, recv_rise, progress, tmr_hit;

    assign win_idx   = arb_gnt[1];
    assign send_rise = mst_send & ~send_d_reg;
    assign recv_rise = mst_receive & ~recv_d_reg;

    i2c_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .update (arb_update),
        .served (sel_reg),
        .gnt    (arb_gnt)
    );

    // Any handshake the current state is waiting for counts as master progress.
    always_comb begin
        progress = 1'b0;
        case (state_reg)
            ST_START:           progress = 1'b1;
            ST_ADDR, ST_WRITE:  progress = send_rise;
            ST_READ:            progress = recv_rise;
            ST_WAIT_END:        progress = mst_ready;
            default:            progress = 1'b0;
        endcase
    end

    assign tmr_hit    = (state_reg != ST_IDLE) && !progress &&
                        (tmr_reg == TMR_W'(TIMEOUT - 1));
    assign arb_update = (state_reg == ST_WAIT_END) && mst_ready;

    // Edge detectors track continuously so a level held across states never re-fires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            send_d_reg <= 1'b0;
            recv_d_reg <= 1'b0;
            tmr_reg    <= '0;
        end else begin
            send_d_reg <= mst_send;
            recv_d_reg <= mst_receive;
            if (state_reg == ST_IDLE || progress) begin
                tmr_reg <= '0;
            end else begin
                tmr_reg <= tmr_reg + TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            wr_ack_reg   <= '0;
            rd_valid_reg <= '0;
            rd_data_reg  <= '0;
            done_reg     <= '0;
            err_reg      <= '0;
            start_reg    <= 1'b0;
            datasend_reg <= '0;
            sended_reg   <= 1'b0;
            received_reg <= 1'b0;
            last_reg     <= 1'b0;
            sel_reg      <= 1'b0;
            rw_reg       <= 1'b0;
            addr_reg     <= '0;
            len_reg      <= '0;
            rem_reg      <= '0;
        end else begin
            start_reg    <= 1'b0;
            sended_reg   <= 1'b0;
            received_reg <= 1'b0;
            wr_ack_reg   <= '0;
            rd_valid_reg <= '0;
            done_reg     <= '0;
            err_reg      <= '0;
            // Registered from the previous cycle's state, so mst_last is still
            // high on the pulse that carries the final byte.
            last_reg <= ((state_reg == ST_ADDR) && (len_reg == '0)) ||
                        (((state_reg == ST_WRITE) || (state_reg == ST_READ)) &&
                         (rem_reg == LEN_W'(1)));
            case (state_reg)
                ST_IDLE: begin
                    if (mst_ready && (req != 2'b00)) begin
                        gnt_reg   <= arb_gnt;
                        sel_reg   <= win_idx;
                        rw_reg    <= req_rw[win_idx];
                        addr_reg  <= addr_arr[win_idx];
                        len_reg   <= len_arr[win_idx];
                        state_reg <= ST_START;
                    end
                end
                ST_START: begin
                    start_reg <= 1'b1;
                    state_reg <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (send_rise) begin
                        datasend_reg <= {addr_reg, rw_reg};
                        sended_reg   <= 1'b1;
                        rem_reg      <= len_reg;
                        if (len_reg == '0) begin
                            state_reg <= ST_WAIT_END;
                        end else if (rw_reg == RW_READ) begin
                            state_reg <= ST_READ;
                        end else begin
                            state_reg <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (send_rise) begin
                        datasend_reg <= wdata_arr[sel_reg];
                        sended_reg   <= 1'b1;
                        wr_ack_reg   <= gnt_reg;
                        if (rem_reg != '0) begin
                            rem_reg <= rem_reg - LEN_W'(1);
                        end
                        if (rem_reg <= LEN_W'(1)) begin
                            state_reg <= ST_WAIT_END;
                        end
                    end
                end
                ST_READ: begin
                    if (recv_rise) begin
                        rd_data_reg  <= mst_datareceive;
                        received_reg <= 1'b1;
                        rd_valid_reg <= gnt_reg;
                        if (rem_reg != '0) begin
                            rem_reg <= rem_reg - LEN_W'(1);
                        end
                        if (rem_reg <= LEN_W'(1)) begin
                            state_reg <= ST_WAIT_END;
                        end
                    end
                end
                ST_WAIT_END: begin
                    if (mst_ready) begin
                        done_reg  <= gnt_reg;
                        gnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
            if (tmr_hit) begin
                done_reg  <= gnt_reg;
                err_reg   <= gnt_reg;
                gnt_reg   <= '0;
                state_reg <= ST_IDLE;
            end
        end
    end

    assign gnt          = gnt_reg;
    assign wr_ack       = wr_ack_reg;
    assign rd_valid     = rd_valid_reg;
    assign rd_data      = rd_data_reg;
    assign done         = done_reg;
    assign err          = err_reg;
    assign mst_start    = start_reg;
    assign mst_datasend = datasend_reg;
    assign mst_sended   = sended_reg;
    assign mst_received = received_reg;
    assign mst_last     = last_reg;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed self-checking bench for i2c_master_arbiter; the bench plays the
// role of both application clients and the I2C master engine.
module tb_i2c_master_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, req_rw;
    logic [13:0] req_addr;
    logic [7:0]  req_len;
    logic [15:0] req_wdata;
    logic [1:0]  gnt, wr_ack, rd_valid, done, err;
    logic [7:0]  rd_data, mst_datasend, mst_datareceive;
    logic        mst_start, mst_ready, mst_send, mst_sended;
    logic        mst_receive, mst_received, mst_last;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    i2c_master_arbiter #(.LEN_W(4), .TIMEOUT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .req_rw          (req_rw),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .req_wdata       (req_wdata),
        .gnt             (gnt),
        .wr_ack          (wr_ack),
        .rd_valid        (rd_valid),
        .rd_data         (rd_data),
        .done            (done),
        .err             (err),
        .mst_start       (mst_start),
        .mst_ready       (mst_ready),
        .mst_send        (mst_send),
        .mst_datasend    (mst_datasend),
        .mst_sended      (mst_sended),
        .mst_receive     (mst_receive),
        .mst_datareceive (mst_datareceive),
        .mst_received    (mst_received),
        .mst_last        (mst_last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({gnt, wr_ack, rd_valid, rd_data, done, err, mst_start,
                    mst_datasend, mst_sended, mst_received, mst_last});
    endfunction

    // Request already driven: expect grant next cycle and start the cycle after.
    task automatic grant_start(input string tag, input logic [1:0] exp_gnt);
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
        chk({tag, "_start_lat"}, 32'(mst_start), 32'd0);
        tick();
        chk({tag, "_start"}, 32'(mst_start), 32'd1);
        mst_ready = 1'b0;
    endtask

    task automatic send_byte(input string tag, input logic [7:0] exp_data,
                             input logic exp_last, input logic [1:0] exp_ack);
        mst_send = 1'b1;
        tick();
        $display("send %s: data=0x%02h last=%0b ack=%b", tag, mst_datasend, mst_last, wr_ack);
        chk({tag, "_sended"}, 32'(mst_sended), 32'd1);
        chk({tag, "_data"}, 32'(mst_datasend), 32'(exp_data));
        chk({tag, "_last"}, 32'(mst_last), 32'(exp_last));
        chk({tag, "_wrack"}, 32'(wr_ack), 32'(exp_ack));
        mst_send = 1'b0;
        tick();
    endtask

    task automatic recv_byte(input string tag, input logic [7:0] data,
                             input logic exp_last, input logic [1:0] exp_valid);
        mst_datareceive = data;
        mst_receive = 1'b1;
        tick();
        $display("recv %s: rd_data=0x%02h last=%0b valid=%b", tag, rd_data, mst_last, rd_valid);
        chk({tag, "_received"}, 32'(mst_received), 32'd1);
        chk({tag, "_valid"}, 32'(rd_valid), 32'(exp_valid));
        chk({tag, "_rdata"}, 32'(rd_data), 32'(data));
        chk({tag, "_last"}, 32'(mst_last), 32'(exp_last));
        mst_receive = 1'b0;
        tick();
    endtask

    task automatic finish_txn(input string tag, input logic [1:0] exp_done);
        mst_ready = 1'b1;
        tick();
        $display("done %s: done=%b err=%b gnt=%b", tag, done, err, gnt);
        chk({tag, "_done"}, 32'(done), 32'(exp_done));
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_gntclr"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        req = '0; req_rw = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        mst_ready = 1'b1; mst_send = 1'b0; mst_receive = 1'b0; mst_datareceive = '0;
        tick();
        tick();
        chk("reset_outputs", out_vec(), 32'd0);
        reset = 1'b1;
        tick();

        // Write 2 bytes from requester 0 to 0x50
        req_addr[6:0] = 7'h50; req_rw[0] = 1'b0; req_len[3:0] = 4'd2;
        req_wdata[7:0] = 8'hA5; req[0] = 1'b1;
        grant_start("wr", 2'b01);
        mst_send = 1'b1;
        tick();
        chk("wr_addr_data", 32'(mst_datasend), 32'hA0);
        chk("wr_addr_sended", 32'(mst_sended), 32'd1);
        tick();
        chk("wr_held_no_repeat", 32'({mst_sended, wr_ack}), 32'd0);
        mst_send = 1'b0;
        tick();
        send_byte("wr_d0", 8'hA5, 1'b0, 2'b01);
        req_wdata[7:0] = 8'h3C;
        chk("wr_last_between", 32'(mst_last), 32'd1);
        send_byte("wr_d1", 8'h3C, 1'b1, 2'b01);
        chk("wr_wait_no_done", 32'(done), 32'd0);
        finish_txn("wr", 2'b01);
        req[0] = 1'b0;

        // Read 3 bytes from requester 1 at 0x68
        req_addr[13:7] = 7'h68; req_rw[1] = 1'b1; req_len[7:4] = 4'd3; req[1] = 1'b1;
        grant_start("rd", 2'b10);
        send_byte("rd_addr", 8'hD1, 1'b0, 2'b00);
        recv_byte("rd_b0", 8'h11, 1'b0, 2'b10);
        recv_byte("rd_b1", 8'h22, 1'b0, 2'b10);
        recv_byte("rd_b2", 8'h33, 1'b1, 2'b10);
        finish_txn("rd", 2'b10);
        req[1] = 1'b0;

        // Address-only probe of 0x3F (read direction) from requester 0
        req_addr[6:0] = 7'h3F; req_rw[0] = 1'b1; req_len[3:0] = 4'd0; req[0] = 1'b1;
        grant_start("probe", 2'b01);
        send_byte("probe_addr", 8'h7F, 1'b1, 2'b00);
        chk("probe_no_rdvalid", 32'(rd_valid), 32'd0);
        finish_txn("probe", 2'b01);
        req[0] = 1'b0;

        // Contention from reset: both request probes continuously; grants alternate
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req_addr = {7'h3F, 7'h3F}; req_rw = 2'b11; req_len = '0;
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            grant_start($sformatf("rr%0d", k), exp_g);
            send_byte($sformatf("rr%0d_addr", k), 8'h7F, 1'b1, 2'b00);
            finish_txn($sformatf("rr%0d", k), exp_g);
        end
        req = 2'b00;
        tick();

        // Timeout: master never requests the address byte
        req_addr[6:0] = 7'h10; req_rw[0] = 1'b0; req_len[3:0] = 4'd1; req[0] = 1'b1;
        grant_start("to", 2'b01);
        for (int k = 0; k < 15; k++) tick();
        chk("to_not_yet", 32'(done), 32'd0);
        tick();
        $display("timeout: done=%b err=%b gnt=%b", done, err, gnt);
        chk("to_done", 32'(done), 32'h1);
        chk("to_err", 32'(err), 32'h1);
        chk("to_gnt_clr", 32'(gnt), 32'd0);
        tick();
        chk("to_wait_ready", 32'(gnt), 32'd0);
        req[0] = 1'b0;
        mst_ready = 1'b1;
        tick();

        // Reset asserted during a read
        req_addr[13:7] = 7'h22; req_rw[1] = 1'b1; req_len[7:4] = 4'd2; req[1] = 1'b1;
        grant_start("mr", 2'b10);
        send_byte("mr_addr", 8'h45, 1'b0, 2'b00);
        recv_byte("mr_b0", 8'h44, 1'b0, 2'b10);
        req[1] = 1'b0;
        mst_receive = 1'b1;
        reset = 1'b0;
        tick();
        chk("mr_reset_outputs", out_vec(), 32'd0);
        reset = 1'b1;
        tick();
        tick();
        chk("mr_held_no_ack", 32'({mst_received, rd_valid, gnt}), 32'd0);
        mst_receive = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
